// File: rtl/serial_bit_tx.sv
// serial_bit_tx: parallel-to-serial line transmitter.
// Each accepted WIDTH-bit word is sent as a start bit (0), the data bits
// LSB first, and a stop bit (1). Every bit lasts CLKS_PER_BIT clocks, and
// the line idles high.
// Optional feature: define SERIAL_BIT_TX_PARITY_EN to insert an even-parity
// bit between the last data bit and the stop bit.
// All outputs come straight from flops. Each output register is loaded from
// the value the state will hold next, so nothing lags the state by a cycle.
module serial_bit_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             ready_reg, ready_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             bit_end;
`ifdef SERIAL_BIT_TX_PARITY_EN
  logic             par_reg, par_next;
`endif

  assign bit_end  = (cnt_reg == CNT_LAST);
  assign in_ready = ready_reg;
  assign tx_out   = tx_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

  // Next-state, baud counter, bit index and shift register sequencing
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
`ifdef SERIAL_BIT_TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid && ready_reg) begin
          state_next = START;
          cnt_next   = '0;
          shift_next = in_data;
`ifdef SERIAL_BIT_TX_PARITY_EN
          par_next   = ^in_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          cnt_next   = '0;
          idx_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shift_next = shift_reg >> 1;
          if (idx_reg == IDX_LAST) begin
`ifdef SERIAL_BIT_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
`ifdef SERIAL_BIT_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output values derived from the upcoming state so that they are registered
  always_comb begin
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef SERIAL_BIT_TX_PARITY_EN
      PARITY:  tx_next = par_next;
`endif
      default: tx_next = 1'b1;
    endcase
    ready_next = (state_next == IDLE);
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == STOP) && (cnt_next == CNT_LAST);
  end

  // State and output registers; reset aborts any frame and idles the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
`ifdef SERIAL_BIT_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Testbench for serial_bit_tx (WIDTH=8, CLKS_PER_BIT=2). Frames are checked
// cycle by cycle against an expected line sequence. That sequence comes
// either from a vector table or from a frame model built from the framing
// rules (start, data LSB first, optional parity, stop).
module tb_serial_bit_tx;

  localparam int WIDTH = 8;
  localparam int CPB   = 2;
`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int NB = WIDTH + 3;
`else
  localparam int NB = WIDTH + 2;
`endif
  localparam int FL = NB * CPB;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready, tx_out, busy, done;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_bit_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_out(tx_out), .busy(busy), .done(done)
  );

  // bits[9] is the first bit on the line (start), bits[0] the stop bit
  typedef struct {
    logic [7:0] data;
    logic [7:0] alt;
    int         chg;
    logic [9:0] bits;
    logic       par;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " tx_out"}, tx_out, 1'b1);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " in_ready"}, in_ready, 1'b1);
  endtask

  // Reference frame: start 0, data LSB first, stop 1
  function automatic logic [9:0] model_bits(input logic [7:0] d);
    logic [9:0] b;
    b[9] = 1'b0;
    for (int i = 0; i < 8; i++) b[8 - i] = d[i];
    b[0] = 1'b1;
    return b;
  endfunction

  // Even parity from a count of ones
  function automatic logic model_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return (ones % 2) == 1;
  endfunction

  // Called at the negedge of frame cycle 0; checks ncyc cycles (ncyc<0: the
  // whole frame plus the following idle cycle, where it stops)
  task automatic expect_frame(input logic [9:0] bits, input logic par, input int chg,
                              input logic [7:0] alt, input int ncyc, input bit drop);
    int lim;
    int b;
    logic e;
    lim = (ncyc < 0) ? FL : ncyc;
    for (int cyc = 0; cyc < lim; cyc++) begin
      if (drop && cyc == 0) in_valid = 1'b0;
      b = cyc / CPB;
      if (b == NB - 1)      e = 1'b1;
      else if (b <= WIDTH)  e = bits[9 - b];
      else                  e = par;
      chk($sformatf("tx_out cyc%0d", cyc), tx_out, e);
      chk($sformatf("busy cyc%0d", cyc), busy, 1'b1);
      chk($sformatf("done cyc%0d", cyc), done, (cyc == FL - 1));
      chk($sformatf("in_ready cyc%0d", cyc), in_ready, 1'b0);
      if (cyc == chg) in_data = alt;
      @(negedge clk);
    end
    if (ncyc < 0) chk_idle("post-frame");
  endtask

  // Start a frame with a one-cycle valid pulse from an idle negedge
  task automatic pulse_frame(input logic [7:0] d, input logic [9:0] bits, input logic par,
                             input int chg, input logic [7:0] alt);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    expect_frame(bits, par, chg, alt, -1, 1'b1);
    $display("frame data=%02h chg=%0d -> checked", d, chg);
  endtask

  initial begin
    logic [7:0] d, a;
    int gap, chg;

    tbl[0] = '{8'hA5, 8'h00, -1, 10'b0101001011, 1'b0};
    tbl[1] = '{8'hA5, 8'h3C,  1, 10'b0101001011, 1'b0};
    tbl[2] = '{8'h00, 8'h00, -1, 10'b0000000001, 1'b0};
    tbl[3] = '{8'hFF, 8'h00, -1, 10'b0111111111, 1'b0};
    tbl[4] = '{8'h07, 8'h00, -1, 10'b0111000001, 1'b1};
    tbl[5] = '{8'h81, 8'h00, -1, 10'b0100000011, 1'b0};

    // Reset held for 3 cycles, then 20 idle cycles
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_idle("in-reset");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_idle("reset-idle");
    end
    $display("reset idle -> checked");

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pulse_frame(tbl[i].data, tbl[i].bits, tbl[i].par, tbl[i].chg, tbl[i].alt);
    end

    // Back-to-back with valid held: 00 then FF, one idle cycle between
    @(negedge clk);
    in_data  = 8'h00;
    in_valid = 1'b1;
    @(negedge clk);
    expect_frame(tbl[2].bits, tbl[2].par, FL - 1, 8'hFF, -1, 1'b0);
    @(negedge clk);
    expect_frame(tbl[3].bits, tbl[3].par, -1, 8'h00, -1, 1'b1);
    $display("back-to-back 00,FF -> checked");

    // Reset during data bit 3 of an A5 frame
    @(negedge clk);
    in_data  = 8'hA5;
    in_valid = 1'b1;
    @(negedge clk);
    expect_frame(tbl[0].bits, tbl[0].par, -1, 8'h00, 4 * CPB, 1'b1);
    chk("tx_out data bit3", tx_out, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async-reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("hold-reset");
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("after-reset");
    pulse_frame(8'h81, tbl[5].bits, tbl[5].par, -1, 8'h00);
    $display("reset mid-frame -> checked");

    // Randomized frames against the model
    for (int i = 0; i < 40; i++) begin
      d   = 8'($urandom_range(0, 255));
      a   = 8'($urandom_range(0, 255));
      chg = int'($urandom_range(0, FL - 1));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk_idle("rand-gap");
      end
      @(negedge clk);
      pulse_frame(d, model_bits(d), model_par(d), chg, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_bit_tx.md
Name: serial_bit_tx

Overview:
- Parallel-to-serial transmitter that drives a one-bit serial line. This is the sending end for the single-bit buffered line path (clk, in, out), and its serial output connects to a downstream line-buffer input.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Frames the word as a start bit (0), data bits LSB first, and a stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles.
- The line idles high.

Parameters:
- WIDTH, 8, data bits per frame (1..32).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  word to transmit; sampled on handshake.
- in_valid  input  1  producer has a word.
- in_ready  output  1  transmitter can accept a word.
- tx_out  output  1  serial line (registered).
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse in the final cycle of the stop bit.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, tx_out=1, in_ready=1, busy=0, done=0.
  - Baud counter, bit index and shift register are cleared.
  - Reset asserted mid-frame aborts the frame immediately. No done pulse is issued, and the line returns high.
- Handshake:
  - A transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - in_ready = (state==IDLE); it is registered and deasserts in the cycle after acceptance.
  - in_data is latched into the shift register at the transfer edge. Later changes on in_data do not affect the frame.
  - in_valid while not ready is ignored; the producer holds it.
- States:
  - IDLE: tx_out=1. On transfer, go to START and clear the counter.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_out=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit WIDTH-1, go to PARITY (feature enabled) or STOP.
  - PARITY (feature only): tx_out=parity for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles. done=1 in the last of these cycles, then go to IDLE.
- Latency: tx_out falls in the first cycle after the transfer edge.
- Frame length:
  - (WIDTH+2)*CLKS_PER_BIT cycles, or (WIDTH+3)*CLKS_PER_BIT with parity.
  - busy=1 for exactly the frame length.
- Back-to-back:
  - After STOP, in_ready=1 for at least one cycle.
  - If in_valid is held, the next start bit begins 1 cycle after the stop bit ends, giving 1 extra idle-high cycle between frames.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - With CLKS_PER_BIT=1, every bit lasts exactly one cycle.
- Width rules:
  - The bit index is sized ceil(log2(WIDTH)), minimum 1 bit.
  - The counter is sized ceil(log2(CLKS_PER_BIT)), minimum 1 bit.
  - No overflow is permitted.
- Glitch-free output: tx_out is taken directly from a flop and is never combinational.

Optional Feature:
- Macro: SERIAL_BIT_TX_PARITY_EN.
- Defined:
  - The PARITY state is inserted between DATA and STOP.
  - The parity bit is the even parity of the latched word: XOR of all WIDTH bits, so the total count of 1s in data plus parity is even.
- Undefined:
  - The PARITY state and its logic are absent, and DATA goes directly to STOP.

Test Plan:
- Reset idle: hold rst_n=0 for 3 cycles, then release with in_valid=0 for 20 cycles -> tx_out=1, in_ready=1, busy=0, done=0 throughout.
- Single frame, WIDTH=8, CLKS_PER_BIT=2, in_data=8'hA5:
  - Pulse in_valid for one cycle.
  - tx_out from the next cycle must be the bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 2 cycles (20 cycles total).
  - busy=1 for those 20 cycles; done=1 only in cycle 20.
- Back-to-back: hold in_valid=1 with in_data=8'h00 and then 8'hFF -> two frames separated by exactly 1 idle-high cycle. The second frame's data bits are all 1.
- Data stability: change in_data to 8'h3C at the second cycle of a frame started with 8'hA5 -> the serialized bits still match 8'hA5.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx_out=1 and in_ready=1 asynchronously, with no done pulse. After release, a new frame of 8'h81 transmits correctly.
- Parity (macro defined): in_data=8'hA5 -> parity bit 0. in_data=8'h07 -> parity bit 1. Frame length is 22 cycles at CLKS_PER_BIT=2.
